fb_port_arbiter: RTL
====================

Name: fb_port_arbiter

Overview:
Shares one single-port 320x240 RGB565 frame-buffer BRAM (76800 x 16) between three requesters:
- the display read path (pixel address and data toward the VGA colour ports);
- the camera capture write path;
- an internal fill engine that clears the frame to a solid colour.

Display reads have priority. Camera writes are absorbed by a small write FIFO. A starvation guard guarantees write progress.

Parameters:
ADDR_W, 17, frame-buffer address width
DATA_W, 16, pixel width (RGB565)
MEM_WORDS, 76800, valid address range 0..MEM_WORDS-1 (320*240)
WFIFO_DEPTH, 4, camera write FIFO entries (power of 2)
MAX_RD_BURST, 8, consecutive read grants allowed while writes are pending

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wr_valid  in  1  camera write request
wr_ready  out  1  camera write accepted this cycle
wr_addr  in  ADDR_W  camera pixel address
wr_data  in  DATA_W  camera pixel
rd_valid  in  1  display read request
rd_ready  out  1  display read granted this cycle
rd_addr  in  ADDR_W  display pixel address
rd_data  out  DATA_W  read pixel
rd_data_valid  out  1  rd_data valid strobe
fill_start  in  1  pulse: start frame fill
fill_color  in  DATA_W  fill pixel, sampled on fill_start
fill_busy  out  1  fill in progress
fill_done  out  1  one-cycle pulse when fill completes
addr_err  out  1  sticky: out-of-range address seen
clr_err  in  1  clears addr_err
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data, valid 1 cycle after a read enable

Behaviour:
- Single clock. reset_n is asynchronous assert, synchronous deassert (handled externally).
- Reset state:
  - FIFO empty, burst_cnt=0, FSM=IDLE.
  - rd_data=0, rd_data_valid=0, fill_busy=0, fill_done=0, addr_err=0.
  - mem_en/mem_we=0 and rd_ready=0 while reset_n=0.
  - Reset mid-operation discards FIFO contents, any in-flight read strobe, and fill progress.
- FSM states:
  - IDLE --fill_start--> FILL: latch fill_color, fill_ptr=0.
  - FILL --last write (fill_ptr=MEM_WORDS-1) granted--> DRAIN.
  - DRAIN --1 cycle, fill_done=1--> IDLE.
  - fill_start outside IDLE is ignored.
- Write source:
  - IDLE: FIFO head.
  - FILL: fill_ptr/fill_color. FIFO entries already queued drain first; fill writes start once the FIFO is empty.
- wr_ready:
  - !fifo_full && state==IDLE. Full status comes from registered count only; no same-cycle pop-through.
  - Camera writes arriving during FILL/DRAIN are back-pressured.
- Arbitration, one BRAM access per cycle, decided combinationally:
  - read grant = rd_valid && !(write_pending && burst_cnt==MAX_RD_BURST);
  - else write grant if write_pending;
  - else idle.
  - rd_ready = read grant.
- burst_cnt:
  - +1 on a read grant while write_pending, saturating at MAX_RD_BURST.
  - Cleared on a write grant or when !write_pending.
- Read latency: rd_data_valid=1 exactly one cycle after rd_valid&&rd_ready. rd_data=mem_rdata on that cycle and holds until the next strobe.
- Out-of-range addresses (>=MEM_WORDS):
  - Write: handshake completes, entry not pushed, addr_err set.
  - Read: granted, mem_en=0; rd_data_valid next cycle with rd_data=0; addr_err set.
- addr_err: set wins over a simultaneous clr_err.
- No read-after-write forwarding. A read may return pre-FIFO data; frame tearing is tolerated.
- Address math: all compare/increment at ADDR_W bits, unsigned. fill_ptr never wraps.

Decomposition:
- Package fb_pkg:
  - FB_W=320, FB_H=240, MEM_WORDS, ADDR_W, DATA_W;
  - typedef pixel_t (16b), fb_addr_t (17b);
  - enum fill_state_e {IDLE, FILL, DRAIN}.
- Sub-module: fb_wr_fifo (synchronous FIFO, WFIFO_DEPTH x (ADDR_W+DATA_W), full/empty/count).

Test Plan:
- Reset, then single read rd_addr=100 with BRAM preloaded 16'hF800 -> rd_ready=1 same cycle; rd_data_valid next cycle with rd_data=16'hF800.
- 4 camera writes (addr 0..3, data 16'h07E0) with no reads -> wr_ready drops only while full; mem_we=1 for 4 cycles; readback of addr 0..3 returns 16'h07E0.
- rd_valid held high continuously with 1 queued write, MAX_RD_BURST=8 -> write granted on cycle 9; rd_ready=0 that cycle only.
- fill_start with fill_color=16'h001F, no reads -> fill_busy for 76800 write grants; fill_done one pulse; wr_ready=0 throughout; all addresses read 16'h001F.
- wr_addr=76800 and rd_addr=80000 -> addr_err=1, no BRAM access, rd_data=0 with strobe; clr_err alone clears it; simultaneous error and clr_err leaves addr_err=1.
- reset_n asserted mid-fill with 3 FIFO entries -> all outputs return to reset values immediately; no mem_we after release.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, types and fill FSM states for the
// frame-buffer port arbiter.
package fb_pkg;

    localparam int unsigned FB_W      = 320;
    localparam int unsigned FB_H      = 240;
    localparam int unsigned MEM_WORDS = FB_W * FB_H;
    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned DATA_W    = 16;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } fill_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO that buffers camera writes while the display
// read path holds the frame-buffer port.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int unsigned Width = ADDR_W + DATA_W,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [Width-1:0]       wdata,
    output logic [Width-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: a cleared count makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (PtrW + 1)'(Depth));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Arbitrates one single-port frame-buffer BRAM between display reads (priority),
// buffered camera writes and a solid-colour fill engine, with a write starvation guard.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W       = fb_pkg::ADDR_W,
    parameter int unsigned DATA_W       = fb_pkg::DATA_W,
    parameter int unsigned MEM_WORDS    = fb_pkg::MEM_WORDS,
    parameter int unsigned WFIFO_DEPTH  = 4,
    parameter int unsigned MAX_RD_BURST = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              addr_err,
    input  logic              clr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(MAX_RD_BURST + 1);
    localparam int unsigned FCNT_W  = $clog2(WFIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] AddrLimit = ADDR_W'(MEM_WORDS);
    localparam logic [ADDR_W-1:0] AddrLast  = ADDR_W'(MEM_WORDS - 1);
    localparam logic [CNT_W-1:0]  BurstMax  = CNT_W'(MAX_RD_BURST);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] fill_ptr_q, fill_ptr_d;
    logic [DATA_W-1:0] fill_color_q, fill_color_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              rd_pend_q, rd_oob_q;
    logic [DATA_W-1:0] rd_hold_q, rd_now;
    logic              addr_err_q, addr_err_set;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [FCNT_W-1:0]  fifo_count;
    logic               unused_fifo_count;

    logic wr_in_range, rd_in_range, wr_accept;
    logic write_pending, rd_grant, wr_grant, fill_grant;

    fb_wr_fifo #(
        .Width (ENTRY_W),
        .Depth (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   ({wr_addr, wr_data}),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign unused_fifo_count = ^fifo_count;

    assign wr_in_range = (wr_addr < AddrLimit);
    assign rd_in_range = (rd_addr < AddrLimit);

    assign wr_ready  = !fifo_full && (state_q == IDLE);
    assign wr_accept = wr_valid && wr_ready;
    // Out-of-range writes complete the handshake but are dropped here.
    assign fifo_push = wr_accept && wr_in_range;

    assign write_pending = !fifo_empty || (state_q == FILL);
    assign rd_grant      = rd_valid && !(write_pending && (burst_cnt_q == BurstMax));
    assign wr_grant      = write_pending && !rd_grant;
    // Queued camera writes drain before any fill write is issued.
    assign fifo_pop      = wr_grant && !fifo_empty;
    assign fill_grant    = wr_grant && fifo_empty;

    assign rd_ready = reset_n && rd_grant;
    assign mem_en   = reset_n && ((rd_grant && rd_in_range) || wr_grant);
    assign mem_we   = reset_n && wr_grant;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_grant) begin
            mem_addr = rd_addr;
        end else if (fifo_pop) begin
            mem_addr  = fifo_head[ENTRY_W-1 -: ADDR_W];
            mem_wdata = fifo_head[DATA_W-1:0];
        end else if (fill_grant) begin
            mem_addr  = fill_ptr_q;
            mem_wdata = fill_color_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_ptr_d   = fill_ptr_q;
        fill_color_d = fill_color_q;
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d      = FILL;
                    fill_ptr_d   = '0;
                    fill_color_d = fill_color;
                end
            end
            FILL: begin
                if (fill_grant) begin
                    if (fill_ptr_q == AddrLast) state_d = DRAIN;
                    else                        fill_ptr_d = fill_ptr_q + 1'b1;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!write_pending || wr_grant) begin
            burst_cnt_d = '0;
        end else if (rd_grant && (burst_cnt_q != BurstMax)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    assign addr_err_set = (wr_accept && !wr_in_range) || (rd_grant && !rd_in_range);
    assign rd_now       = rd_oob_q ? '0 : mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fill_ptr_q   <= '0;
            fill_color_q <= '0;
            burst_cnt_q  <= '0;
            rd_pend_q    <= 1'b0;
            rd_oob_q     <= 1'b0;
            rd_hold_q    <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_ptr_q   <= fill_ptr_d;
            fill_color_q <= fill_color_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_pend_q    <= rd_grant;
            rd_oob_q     <= !rd_in_range;
            if (rd_pend_q) rd_hold_q <= rd_now;
            if (addr_err_set)  addr_err_q <= 1'b1;
            else if (clr_err)  addr_err_q <= 1'b0;
        end
    end

    assign rd_data_valid = rd_pend_q;
    assign rd_data       = rd_pend_q ? rd_now : rd_hold_q;
    assign fill_busy     = (state_q == FILL);
    assign fill_done     = (state_q == DRAIN);
    assign addr_err      = addr_err_q;

endmodule
